// File: rtl/bus_wr_demux.sv
// Write-side demultiplexer: decodes a binary destination index into a one-hot
// select, holds select/data until the destination acks or a timeout, then responds.
module bus_wr_demux #(
  parameter int COUNT   = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_idx,
  input  logic [WIDTH-1:0] req_data,
  output logic [COUNT-1:0] dst_sel,
  output logic [WIDTH-1:0] dst_data,
  input  logic [COUNT-1:0] dst_ack,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [7:0] TMO_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

  function automatic logic [COUNT-1:0] onehot_f(input logic [3:0] idx);
    logic [COUNT-1:0] sel;
    for (int i = 0; i < COUNT; i++) begin
      sel[i] = (idx == 4'(i));
    end
    return sel;
  endfunction

  state_t           state_r, state_nx;
  logic             req_ready_r, req_ready_nx;
  logic [COUNT-1:0] dst_sel_r, dst_sel_nx;
  logic [WIDTH-1:0] dst_data_r, dst_data_nx;
  logic             resp_valid_r, resp_valid_nx;
  logic             resp_err_r, resp_err_nx;
  logic [7:0]       timer_r, timer_nx;
  logic             idx_ok_s;
  logic             ack_hit_s;

  // dst_sel_r is the one-hot of the latched index, so masking picks only that ack bit
  assign idx_ok_s  = ({1'b0, req_idx} < 5'(COUNT));
  assign ack_hit_s = |(dst_ack & dst_sel_r);

  // Next-state and next-output decode
  always_comb begin
    state_nx      = state_r;
    req_ready_nx  = req_ready_r;
    dst_sel_nx    = dst_sel_r;
    dst_data_nx   = dst_data_r;
    resp_valid_nx = resp_valid_r;
    resp_err_nx   = resp_err_r;
    timer_nx      = timer_r;
    case (state_r)
      IDLE: begin
        req_ready_nx  = 1'b1;
        dst_sel_nx    = {COUNT{1'b0}};
        resp_valid_nx = 1'b0;
        resp_err_nx   = 1'b0;
        if (req_valid && req_ready_r) begin
          req_ready_nx = 1'b0;
          if (idx_ok_s) begin
            dst_sel_nx  = onehot_f(req_idx);
            dst_data_nx = req_data;
            timer_nx    = 8'd0;
            state_nx    = ACTIVE;
          end else begin
            resp_err_nx   = 1'b1;
            resp_valid_nx = 1'b1;
            state_nx      = RESP;
          end
        end else begin
          req_ready_nx = 1'b1;
        end
      end
      ACTIVE: begin
        // Ack takes priority over a timeout expiring on the same edge
        if (ack_hit_s) begin
          dst_sel_nx    = {COUNT{1'b0}};
          resp_err_nx   = 1'b0;
          resp_valid_nx = 1'b1;
          state_nx      = RESP;
        end else if ((TIMEOUT != 0) && (timer_r == TMO_LAST)) begin
          dst_sel_nx    = {COUNT{1'b0}};
          resp_err_nx   = 1'b1;
          resp_valid_nx = 1'b1;
          state_nx      = RESP;
        end else begin
          timer_nx = timer_r + 8'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_nx = 1'b0;
          resp_err_nx   = 1'b0;
          req_ready_nx  = 1'b1;
          state_nx      = IDLE;
        end else begin
          resp_valid_nx = 1'b1;
        end
      end
      default: begin
        state_nx      = IDLE;
        req_ready_nx  = 1'b0;
        dst_sel_nx    = {COUNT{1'b0}};
        resp_valid_nx = 1'b0;
        resp_err_nx   = 1'b0;
        timer_nx      = 8'd0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r      <= IDLE;
      req_ready_r  <= 1'b0;
      dst_sel_r    <= {COUNT{1'b0}};
      dst_data_r   <= {WIDTH{1'b0}};
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      timer_r      <= 8'd0;
    end else begin
      state_r      <= state_nx;
      req_ready_r  <= req_ready_nx;
      dst_sel_r    <= dst_sel_nx;
      dst_data_r   <= dst_data_nx;
      resp_valid_r <= resp_valid_nx;
      resp_err_r   <= resp_err_nx;
      timer_r      <= timer_nx;
    end
  end

  assign req_ready  = req_ready_r;
  assign dst_sel    = dst_sel_r;
  assign dst_data   = dst_data_r;
  assign resp_valid = resp_valid_r;
  assign resp_err   = resp_err_r;

endmodule

// File: tb/tb_bus_wr_demux.sv
// Directed bench for bus_wr_demux (COUNT=4, WIDTH=32, TIMEOUT=16).
module tb_bus_wr_demux;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_idx;
  logic [31:0] req_data;
  logic [3:0]  dst_sel;
  logic [31:0] dst_data;
  logic [3:0]  dst_ack;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_err;

  int n_pass  = 0;
  int n_check = 0;

  bus_wr_demux #(.COUNT(4), .WIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_idx(req_idx), .req_data(req_data),
    .dst_sel(dst_sel), .dst_data(dst_data), .dst_ack(dst_ack),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_check++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    resetn = 1'b0; req_valid = 1'b0; req_idx = 4'd0; req_data = 32'd0;
    dst_ack = 4'd0; resp_ready = 1'b0;
    step();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_dst_sel", dst_sel, 0);
    chk("rst_dst_data", dst_data, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_err", resp_err, 0);
    resetn = 1'b1;
    step();
    chk("post_rst_req_ready", req_ready, 1);

    // Normal write to index 2, ack two cycles after select
    req_valid = 1'b1; req_idx = 4'd2; req_data = 32'hDEADBEEF;
    step();
    req_valid = 1'b0; req_idx = 4'd0; req_data = 32'h0;
    chk("t1_dst_sel", dst_sel, 4'b0100);
    chk("t1_dst_data", dst_data, 32'hDEADBEEF);
    chk("t1_req_ready_low", req_ready, 0);
    step();
    chk("t1_sel_hold", dst_sel, 4'b0100);
    step();
    chk("t1_sel_hold2", dst_sel, 4'b0100);
    chk("t1_no_resp_yet", resp_valid, 0);
    dst_ack = 4'b0100;
    step();
    dst_ack = 4'b0000;
    chk("t1_resp_valid", resp_valid, 1);
    chk("t1_resp_err", resp_err, 0);
    chk("t1_sel_clear", dst_sel, 0);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("t1_resp_done", resp_valid, 0);
    chk("t1_req_ready", req_ready, 1);

    // Out-of-range index goes straight to an error response
    req_valid = 1'b1; req_idx = 4'd5; req_data = 32'h55555555;
    step();
    req_valid = 1'b0;
    chk("t2_dst_sel", dst_sel, 0);
    chk("t2_resp_valid", resp_valid, 1);
    chk("t2_resp_err", resp_err, 1);
    chk("t2_req_ready", req_ready, 0);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("t2_resp_done", resp_valid, 0);
    chk("t2_req_ready_back", req_ready, 1);

    // No ack: select held 16 cycles then timeout error
    req_valid = 1'b1; req_idx = 4'd1; req_data = 32'hCAFEF00D;
    step();
    req_valid = 1'b0;
    chk("t3_dst_sel_first", dst_sel, 4'b0010);
    for (int i = 1; i < 16; i++) begin
      step();
      chk("t3_dst_sel_hold", dst_sel, 4'b0010);
      chk("t3_no_resp", resp_valid, 0);
    end
    step();
    chk("t3_dst_sel_clear", dst_sel, 0);
    chk("t3_resp_valid", resp_valid, 1);
    chk("t3_resp_err", resp_err, 1);

    // Response back-pressure with a pending request that must wait
    req_valid = 1'b1; req_idx = 4'd0; req_data = 32'h12345678;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t5_resp_valid_hold", resp_valid, 1);
      chk("t5_resp_err_hold", resp_err, 1);
      chk("t5_req_ready_low", req_ready, 0);
      chk("t5_dst_sel_idle", dst_sel, 0);
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("t5_resp_done", resp_valid, 0);
    chk("t5_req_ready", req_ready, 1);
    chk("t5_not_accepted", dst_sel, 0);

    // Pending request now accepted; ack on an unselected bit is ignored
    step();
    req_valid = 1'b0; req_data = 32'h0;
    chk("t4_dst_sel", dst_sel, 4'b0001);
    chk("t4_dst_data", dst_data, 32'h12345678);
    dst_ack = 4'b1000;
    step();
    dst_ack = 4'b0000;
    chk("t4_wrong_ack_ignored", resp_valid, 0);
    chk("t4_sel_hold", dst_sel, 4'b0001);
    step();
    step();
    step();
    chk("t4_still_waiting", resp_valid, 0);
    dst_ack = 4'b0001;
    resp_ready = 1'b1;
    step();
    dst_ack = 4'b0000;
    chk("t4_resp_valid", resp_valid, 1);
    chk("t4_resp_err", resp_err, 0);
    step();
    resp_ready = 1'b0;
    chk("t4_resp_consumed", resp_valid, 0);
    chk("t4_req_ready", req_ready, 1);

    // Reset pulsed while ACTIVE drops the transaction
    req_valid = 1'b1; req_idx = 4'd3; req_data = 32'hA5A5A5A5;
    step();
    req_valid = 1'b0;
    chk("t6_dst_sel", dst_sel, 4'b1000);
    #2;
    resetn = 1'b0;
    #1;
    chk("t6_async_dst_sel", dst_sel, 0);
    chk("t6_async_resp_valid", resp_valid, 0);
    chk("t6_async_req_ready", req_ready, 0);
    step();
    resetn = 1'b1;
    dst_ack = 4'b1000;
    step();
    dst_ack = 4'b0000;
    chk("t6_req_ready", req_ready, 1);
    chk("t6_no_stale_resp", resp_valid, 0);
    step();
    chk("t6_no_stale_resp2", resp_valid, 0);
    chk("t6_dst_sel_idle", dst_sel, 0);

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule

// File: doc/bus_wr_demux.md
Name: bus_wr_demux

Overview:
- Write-path counterpart of the read-side one-hot-select mux.
- Accepts a write request carrying a binary destination index and data, and decodes the index into a one-hot destination select.
- Holds select and data until the chosen destination acknowledges or a timeout expires, then returns a single response to the initiator.
- Sits between a bus master and up to 16 register/memory destinations.

Parameters:
- COUNT, 4, number of destinations (1..16).
- WIDTH, 32, data width in bits.
- TIMEOUT, 16, cycles to wait for an ack before erroring (1..255); 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_idx  in  4  binary destination index.
- req_data  in  WIDTH  write data.
- dst_sel  out  COUNT  one-hot destination select.
- dst_data  out  WIDTH  write data to destinations (broadcast).
- dst_ack  in  COUNT  per-destination acknowledge.
- resp_valid  out  1  response present.
- resp_ready  in  1  initiator accepts the response.
- resp_err  out  1  1 = bad index or timeout; valid only while resp_valid=1.

Behaviour:
- Reset (resetn low, asynchronous): state IDLE; req_ready=0, dst_sel=0, dst_data=0, resp_valid=0, resp_err=0, timer=0.
- req_ready is registered. It rises on the first clk edge after resetn deasserts.
- All outputs are registered.
- States: IDLE, ACTIVE, RESP.
- IDLE:
  - req_ready=1, dst_sel=0.
  - Handshake occurs on a clk edge with req_valid=1 and req_ready=1.
  - On handshake, req_ready drops to 0 next cycle.
  - If req_idx < COUNT: latch index; dst_sel <= 1<<req_idx; dst_data <= req_data; timer <= 0; go ACTIVE. dst_sel is visible 1 cycle after the handshake edge.
  - If req_idx >= COUNT: dst_sel stays 0; resp_err <= 1; go RESP directly. No destination is touched.
- ACTIVE:
  - dst_sel and dst_data are held stable.
  - Each cycle, sample dst_ack[latched index] only. Acks on unselected bits are ignored.
  - Ack seen: dst_sel <= 0, resp_err <= 0, resp_valid <= 1, go RESP. resp_valid rises 1 cycle after the ack edge.
  - No ack: timer increments. When timer == TIMEOUT-1 with no ack, take the error path: dst_sel <= 0, resp_err <= 1, resp_valid <= 1, go RESP.
  - Ack and timeout on the same edge: the ack wins (resp_err=0).
  - TIMEOUT=0: wait indefinitely.
- RESP:
  - resp_valid=1 and resp_err are held until resp_ready=1 on a clk edge.
  - After that edge: resp_valid <= 0, resp_err <= 0, req_ready <= 1, go IDLE.
  - resp_ready may already be high when resp_valid rises; the response is consumed on the first edge at which resp_valid=1.
- Throughput: one outstanding request. Minimum request-to-request spacing is 3 cycles with an immediate ack and resp_ready tied high.
- dst_data retains its last value after the transaction; it is don't-care while dst_sel=0.
- Reset mid-transaction: all outputs clear asynchronously. The in-flight request is dropped and no response is issued.
- req_idx and req_data are sampled only at the handshake edge. Changes at other times have no effect.

Test Plan:
- Reset, then req_idx=2, req_data=0xDEADBEEF, ack on bit 2 two cycles after dst_sel rises -> dst_sel=4'b0100 one cycle after the handshake, dst_data=0xDEADBEEF; resp_valid=1 and resp_err=0 one cycle after the ack; req_ready=1 after resp_ready.
- req_idx=5 with COUNT=4 -> dst_sel never leaves 0; resp_valid=1, resp_err=1 one cycle after the handshake.
- req_idx=1, no ack, TIMEOUT=16 -> dst_sel=4'b0010 held for 16 cycles, then 0; resp_err=1.
- req_idx=0 with ack pulsed on bit 3 only, then bit 0 at cycle 5 -> the bit 3 ack is ignored; response with resp_err=0 follows the bit 0 ack.
- resp_ready held low for 10 cycles -> resp_valid and resp_err stable and req_ready=0 throughout; a new req_valid is not accepted until after the response handshake.
- resetn pulsed low while in ACTIVE -> dst_sel, resp_valid and req_ready go to 0 immediately; after release, req_ready=1 on the next edge and no stale response appears.
